// File: rtl/fu_latency_if.sv
// ============================================================================
// Module : fu_latency_if
// Issue/result bundle between an EX-stage issuer and a multi-cycle FU sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fu_latency_if #(
    parameter int DATA_W = 32,
    parameter int LAT_W  = 4
);
    logic              issue;
    logic [LAT_W-1:0]  latency;
    logic              flush;
    logic [DATA_W-1:0] fu_result;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic [LAT_W-1:0]  op_lat;

    modport master (
        output issue, latency, flush, fu_result,
        input  busy, done, result, op_lat
    );

    modport slave (
        input  issue, latency, flush, fu_result,
        output busy, done, result, op_lat
    );
endinterface

`default_nettype wire

// File: rtl/fu_latency_ctrl.sv
// ============================================================================
// Module : fu_latency_ctrl
// Multi-cycle FU sequencer: holds BUSY for a per-op latency, captures the FU
// result and strobes done. Optional STALL_STATS_EN adds a busy-cycle counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fu_latency_ctrl #(
    parameter int DATA_W  = 32,
    parameter int LAT_W   = 4,
    parameter int MAX_LAT = 15
) (
    input  wire logic        clk,
    input  wire logic        rst,
`ifdef STALL_STATS_EN
    input  wire logic        stat_clr,
    output logic [31:0]      stall_cycles,
`endif
    fu_latency_if.slave      bus
);

    localparam logic [LAT_W-1:0] c_MAX_LAT = LAT_W'(MAX_LAT);
    localparam logic [LAT_W-1:0] c_ONE     = LAT_W'(1);
    localparam logic [LAT_W-1:0] c_TWO     = LAT_W'(2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [LAT_W-1:0]    r_cnt;
    logic [LAT_W-1:0]    r_op_lat;
    logic [DATA_W-1:0]   r_result;
    logic                r_done;

    logic [LAT_W-1:0]    w_leff;
    logic                w_can_issue;
    logic                w_busy;

    assign w_leff      = (bus.latency > c_MAX_LAT) ? c_MAX_LAT : bus.latency;
    assign w_can_issue = (r_state == S_IDLE) || (r_state == S_DONE);

    // Cycle 0 of an op stalls combinationally from issue; flush and reset mask everything.
    assign w_busy = !rst && !bus.flush &&
                    ((r_state == S_COUNT) ||
                     (w_can_issue && bus.issue && (w_leff != '0)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op_lat <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.flush) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        r_state <= S_IDLE;
                        if (bus.issue) begin
                            r_op_lat <= w_leff;
                            if (w_leff == c_ONE) begin
                                r_result <= bus.fu_result;
                                r_state  <= S_DONE;
                                r_done   <= 1'b1;
                            end else if (w_leff != '0) begin
                                r_cnt   <= w_leff - c_TWO;
                                r_state <= S_COUNT;
                            end
                        end
                    end
                    S_COUNT: begin
                        if (r_cnt == '0) begin
                            r_result <= bus.fu_result;
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - c_ONE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.busy   = w_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.op_lat = r_op_lat;

`ifdef STALL_STATS_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (stat_clr) begin
            r_stall_cycles <= '0;
        end else if (w_busy && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

`default_nettype wire
